// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for a radix-2 SDF FFT pipeline: accepts framed samples,
// generates advance/flush, per-stage butterfly selects, twiddle address and output framing.
module fft_seq_ctrl #(
  parameter int unsigned N        = 128,
  parameter int unsigned LOGN     = 7,
  parameter int unsigned PIPE_LAT = 127
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_start,
  output logic            in_ready,
  output logic            adv,
  output logic            flush,
  output logic [LOGN-1:0] bf_sel,
  output logic [LOGN-2:0] tw_addr,
  output logic            out_valid,
  output logic            out_start,
  output logic            frame_done,
  output logic            busy,
  output logic            err_sync
);

  localparam int unsigned     CW      = $clog2(PIPE_LAT + 1);
  localparam logic [CW-1:0]   FullCnt = CW'(PIPE_LAT);
  localparam logic [LOGN-1:0] LastIdx = LOGN'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e          state_q;
  logic [LOGN-1:0] in_cnt_q, out_cnt_q, cur_idx;
  logic [CW-1:0]   fill_q, occ_q, occ_d;
  logic            start_acc, acc;

  // Outputs are forced to their idle values while rst is high, not just after the edge.
  always_comb begin
    start_acc = !rst && (state_q == StIdle) && in_valid && in_start;
    acc       = start_acc || (!rst && (state_q == StRun) && in_valid);
    flush     = !rst && (state_q == StFlush);
    adv       = acc || flush;
    in_ready  = rst || (state_q != StFlush);
    busy      = !rst && (state_q != StIdle);
    cur_idx   = (start_acc || rst) ? '0 : in_cnt_q;
    for (int s = 0; s < LOGN; s++) begin
      bf_sel[s] = cur_idx[LOGN-1-s];
    end
    tw_addr   = cur_idx[LOGN-2:0];
    out_valid = adv && (fill_q == FullCnt) && (occ_q != '0);
    out_start = out_valid && (out_cnt_q == '0);
    occ_d     = occ_q + CW'(acc) - CW'(out_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      fill_q     <= '0;
      occ_q      <= '0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      frame_done <= out_valid && (out_cnt_q == LastIdx);
      occ_q      <= occ_d;
      if (acc) begin
        in_cnt_q <= start_acc ? LOGN'(1) : in_cnt_q + 1'b1;
      end
      if (out_valid) begin
        out_cnt_q <= out_cnt_q + 1'b1;
      end
      // Fill restarts with each new frame from idle; the start cycle is advance #1.
      if (start_acc) begin
        fill_q <= CW'(1);
      end else if (adv && (fill_q != FullCnt)) begin
        fill_q <= fill_q + 1'b1;
      end
      if ((state_q == StRun) && acc && in_start && (in_cnt_q != '0)) begin
        err_sync <= 1'b1;
      end
      unique case (state_q)
        StIdle:  if (start_acc) state_q <= StRun;
        StRun:   if ((in_cnt_q == '0) && !in_valid) state_q <= StFlush;
        StFlush: if (occ_d == '0) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: stimulus queues expected output indices,
// a negedge monitor pops them as out_valid appears.
module tb_fft_seq_ctrl;

  localparam int N = 128;
  localparam int LOGN = 7;
  localparam int PL = 127;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_start = 1'b0;
  logic            in_ready, adv, flush, out_valid, out_start, frame_done, busy, err_sync;
  logic [LOGN-1:0] bf_sel;
  logic [LOGN-2:0] tw_addr;

  int total = 0;
  int bad = 0;
  int q[$];
  int adv_cnt = 0;
  int outs = 0;
  int starts = 0;
  int fd_cnt = 0;
  int start_adv = 0;
  bit fd_exp = 1'b0;

  fft_seq_ctrl #(.N(N), .LOGN(LOGN), .PIPE_LAT(PL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_ready  (in_ready),
    .adv       (adv),
    .flush     (flush),
    .bf_sel    (bf_sel),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .out_start (out_start),
    .frame_done(frame_done),
    .busy      (busy),
    .err_sync  (err_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bitrev(input int i);
    logic [LOGN-1:0] v, r;
    v = LOGN'(i);
    for (int s = 0; s < LOGN; s++) r[s] = v[LOGN-1-s];
    return int'(r);
  endfunction

  // Monitor: pops one expected index per output and tracks frame_done timing.
  always @(negedge clk) begin
    int e;
    if (rst) begin
      fd_exp = 1'b0;
    end else begin
      if (adv) adv_cnt++;
      if (frame_done || fd_exp) chk("frame_done", int'(frame_done), int'(fd_exp));
      if (frame_done) fd_cnt++;
      fd_exp = 1'b0;
      if (out_valid) begin
        outs++;
        if (q.size() == 0) begin
          chk("out_unexpected", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("out_start", int'(out_start), int'(e == 0));
          fd_exp = (e == N - 1);
          if (out_start) begin
            starts++;
            start_adv = adv_cnt;
          end
        end
      end else if (out_start) begin
        chk("out_start_no_valid", int'(out_valid), 1);
      end
    end
  end

  task automatic drive(input bit v, input bit s);
    @(posedge clk);
    #1;
    in_valid = v;
    in_start = s;
    #1;
  endtask

  task automatic send(input int idx, input bit s);
    drive(1'b1, s);
    q.push_back(idx);
    chk("adv_on_accept", int'(adv), 1);
    chk("no_flush", int'(flush), 0);
    chk("bf_sel", int'(bf_sel), bitrev(idx));
    chk("tw_addr", int'(tw_addr), idx % 64);
  endtask

  task automatic frame(input int n, input int stall_at, input int misframe_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < 5; k++) begin
          drive(1'b0, 1'b0);
          chk("stall_adv", int'(adv), 0);
          chk("stall_bf_sel", int'(bf_sel), bitrev(i % N));
          chk("stall_tw_addr", int'(tw_addr), i % 64);
        end
      end
      send(i % N, (i % N == 0) || (i == misframe_at));
    end
  endtask

  task automatic wait_idle(output int nflush);
    int n;
    n = 0;
    nflush = 0;
    do begin
      drive(1'b0, 1'b0);
      if (flush) nflush++;
      n++;
    end while (busy && n < 1000);
    chk("reach_idle", int'(busy), 0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf, o0, s0, f0, b0, n;

    // Reset values while rst is held
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("rst_adv", int'(adv), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_bf_sel", int'(bf_sel), 0);
    chk("rst_tw_addr", int'(tw_addr), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_err_sync", int'(err_sync), 0);
    rst = 1'b0;

    // Samples without in_start are discarded in idle
    drive(1'b1, 1'b0);
    chk("idle_discard_adv", int'(adv), 0);
    chk("idle_in_ready", int'(in_ready), 1);
    drive(1'b1, 1'b0);
    chk("idle_discard_busy", int'(busy), 0);
    drive(1'b0, 1'b0);

    // Single frame
    o0 = outs; s0 = starts; f0 = fd_cnt; b0 = adv_cnt;
    frame(128, -1, -1);
    wait_idle(nf);
    chk("single_flush_cycles", nf, 127);
    chk("single_outs", outs - o0, 128);
    chk("single_starts", starts - s0, 1);
    chk("single_start_adv", start_adv - b0, 128);
    chk("single_frame_done", fd_cnt - f0, 1);
    chk("single_q_empty", q.size(), 0);
    chk("single_err", int'(err_sync), 0);

    // Back-to-back frames
    o0 = outs; s0 = starts; f0 = fd_cnt;
    frame(256, -1, -1);
    wait_idle(nf);
    chk("b2b_flush_cycles", nf, 127);
    chk("b2b_outs", outs - o0, 256);
    chk("b2b_starts", starts - s0, 2);
    chk("b2b_frame_done", fd_cnt - f0, 2);
    chk("b2b_err", int'(err_sync), 0);

    // Stall at index 40
    o0 = outs; f0 = fd_cnt;
    frame(128, 40, -1);
    wait_idle(nf);
    chk("stall_outs", outs - o0, 128);
    chk("stall_frame_done", fd_cnt - f0, 1);
    chk("stall_flush_cycles", nf, 127);

    // Misframe: in_start at index 64
    o0 = outs; s0 = starts;
    frame(65, -1, 64);
    chk("misframe_err_set", int'(err_sync), 0);
    drive(1'b1, 1'b0);
    q.push_back(65);
    chk("misframe_err", int'(err_sync), 1);
    for (int i = 66; i < 128; i++) send(i, 1'b0);
    wait_idle(nf);
    chk("misframe_err_sticky", int'(err_sync), 1);
    chk("misframe_outs", outs - o0, 128);
    chk("misframe_starts", starts - s0, 1);

    // Reset in the middle of a flush, with 50 samples still in flight
    frame(128, -1, -1);
    nf = 0;
    n = 0;
    while (nf < 77 && n < 500) begin
      drive(1'b0, 1'b0);
      if (flush) nf++;
      n++;
    end
    chk("midflush_reached", nf, 77);
    drive(1'b0, 1'b0);
    chk("midflush_still_flushing", int'(flush), 1);
    rst = 1'b1;
    q.delete();
    o0 = outs; f0 = fd_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_flush", int'(flush), 0);
    chk("post_rst_adv", int'(adv), 0);
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_err", int'(err_sync), 0);
    chk("post_rst_frame_done", int'(frame_done), 0);
    chk("post_rst_bf_sel", int'(bf_sel), 0);
    repeat (140) drive(1'b0, 1'b0);
    chk("post_rst_no_outs", outs - o0, 0);
    chk("post_rst_no_frame_done", fd_cnt - f0, 0);

    // Recovery after reset
    o0 = outs; s0 = starts;
    frame(128, -1, -1);
    wait_idle(nf);
    chk("recover_outs", outs - o0, 128);
    chk("recover_starts", starts - s0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 Parameter N, default 128: FFT frame length in samples, power of two.
REQ-002 Parameter LOGN, default 7: log2(N), equal to the number of pipeline stages.
REQ-003 Parameter PIPE_LAT, default 127: pipeline advances from a sample entering to its result leaving (SDF delay sum N-1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  an input sample is present this cycle.
REQ-007 in_start  input  1  the present sample is sample 0 of a frame; qualified by in_valid.
REQ-008 in_ready  output  1  the controller accepts input this cycle.
REQ-009 adv  output  1  pipeline advance enable for all delay lines and butterflies.
REQ-010 flush  output  1  the pipeline is advancing with zero data and no real input.
REQ-011 bf_sel  output  LOGN  per-stage butterfly/bypass select.
REQ-012 tw_addr  output  LOGN-1  twiddle ROM address for stage 0.
REQ-013 out_valid  output  1  a real result leaves the pipeline this cycle.
REQ-014 out_start  output  1  out_valid for output index 0 of a frame.
REQ-015 frame_done  output  1  one-cycle pulse the cycle after the last output (index N-1) of a frame.
REQ-016 busy  output  1  the state is not IDLE.
REQ-017 err_sync  output  1  sticky framing error flag.

Function
REQ-018 States: IDLE, RUN, FLUSH. acc = in_valid && in_ready.
REQ-019 IDLE -> RUN on in_valid && in_start; that sample is accepted as index 0. Samples without in_start in IDLE are discarded: in_ready=1, acc counted as 0.
REQ-020 RUN -> FLUSH when in_cnt==0 and in_valid==0, that is, at a frame boundary with no next frame present.
REQ-021 FLUSH -> IDLE on the cycle occ reaches 0 after that cycle's update. In FLUSH, in_ready=0, flush=1 and adv=1 every cycle.
REQ-022 RUN, mid-frame with in_valid==0: stall. adv=0 and all counters hold.
REQ-023 in_ready=1 in IDLE and RUN; in_ready=0 in FLUSH.
REQ-024 adv = (acc in RUN, or the IDLE start acceptance) or flush; the function is combinational from state and inputs.
REQ-025 in_cnt (LOGN bits) increments mod N on each accepted sample, wraps N-1 -> 0, and is set to 1 on the IDLE start acceptance.
REQ-026 bf_sel[s] = bit LOGN-1-s of the current sample index; tw_addr = current index[LOGN-2:0]. Current index = 0 on an IDLE start acceptance, otherwise in_cnt. Both are combinational.
REQ-027 fill_cnt counts adv and saturates at PIPE_LAT; it clears on the IDLE -> RUN transition, and that cycle's advance counts as 1.
REQ-028 occ counts real samples inside the pipeline: occ_next = occ + acc - out_valid. It holds a maximum of PIPE_LAT and never underflows.
REQ-029 out_valid = adv && fill_cnt==PIPE_LAT (value before the update) && occ!=0.
REQ-030 out_cnt (LOGN bits) increments mod N on out_valid; out_start = out_valid && out_cnt==0.
REQ-031 frame_done is registered: it is 1 exactly one cycle after out_valid with out_cnt==N-1.
REQ-032 err_sync sets when acc && in_start && in_cnt!=0 in RUN. That sample is still accepted as index in_cnt, and framing is not realigned.
REQ-033 Back-to-back frames: in_start at in_cnt==0 in RUN continues without a bubble, with no FLUSH.
REQ-034 Simultaneous acc and out_valid leave occ unchanged.

Reset
REQ-035 On rst=1 at a clock edge: state=IDLE and in_cnt, out_cnt, fill_cnt and occ are all 0; frame_done=0 and err_sync=0. This takes priority over all other events, including mid-frame and mid-flush.
REQ-036 During and after reset: adv=0, flush=0, out_valid=0, out_start=0, busy=0, in_ready=1, bf_sel=0, tw_addr=0.

Verification
REQ-037 Single frame: 128 consecutive valid samples with in_start on the first -> FLUSH for 127 cycles. There are 128 out_valid pulses; out_start comes on the 128th adv cycle after the start. frame_done follows the last output. The block is back in IDLE with occ=0.
REQ-038 Two back-to-back frames with in_start at index 0 and 128 -> no FLUSH between frames, 256 contiguous outputs, out_start twice, frame_done twice, err_sync=0.
REQ-039 Stall: in_valid low for 5 cycles at index 40 -> adv=0 and bf_sel/tw_addr hold for those 5 cycles; the output count is still exactly 128.
REQ-040 Misframe: in_start asserted at index 64 -> err_sync=1 and stays set; index 64 is accepted normally.
REQ-041 Counter checks: bf_sel[0] toggles every 64 accepted samples and bf_sel[6] every sample; tw_addr wraps 63 -> 0.
REQ-042 Reset mid-FLUSH (occ=50) -> next cycle IDLE, all outputs at their reset values, and no frame_done pulse.
